// File: rtl/therm_to_bin_pipe.sv
// -----------------------------------------------------------------------------
// therm_to_bin_pipe
//
// Two-stage thermometer-to-binary encoder with bubble correction. Each
// 2**WIDTH-bit thermometer word is scrubbed with a 3-tap majority filter,
// checked for legality, encoded to the index of its highest set bit and
// delivered over a valid/ready handshake together with error flags.
//
// Ports:
//   clk         rising-edge clock
//   resetn      asynchronous active-low reset (drops in-flight words)
//   din         thermometer word, bit k set means level >= k
//   din_valid   din is presented
//   din_ready   stage 1 can take din this cycle (depends on state + dout_ready)
//   dout        binary index of the highest set bit of the filtered word
//   dout_valid  dout and the flags are valid
//   dout_ready  downstream accepts dout this cycle
//   bubble_err  filter changed the word, or the filtered word is still illegal
//   zero_err    filtered word is all zeros
//   err_count   saturating count of delivered words carrying either flag
// -----------------------------------------------------------------------------

// One majority tap of the bubble filter.
module therm_maj_lane (
    input  logic lo,
    input  logic mid,
    input  logic hi,
    output logic c
);
    assign c = (lo & mid) | (lo & hi) | (mid & hi);
endmodule

module therm_to_bin_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [(1<<WIDTH)-1:0]   din,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic [WIDTH-1:0]        dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    bubble_err,
    output logic                    zero_err,
    output logic [CNT_W-1:0]        err_count
);
    localparam int N = 1 << WIDTH;

    typedef struct packed {
        logic [N-1:0] c;
        logic         bub;
        logic         zero;
    } s1_t;

    // ---------------------------------------------------------------- filter
    // Pad with an implicit 1 below bit 0 and an implicit 0 above bit N-1 so
    // the end taps see the values a legal code would have there.
    logic [N+1:0] t_ext;
    logic [N-1:0] c_filt;
    logic         c_zero;
    logic         c_hole;
    logic         c_bub;

    assign t_ext = {1'b0, din, 1'b1};

    for (genvar k = 0; k < N; k++) begin : g_lane
        therm_maj_lane u_lane (
            .lo  (t_ext[k]),
            .mid (t_ext[k+1]),
            .hi  (t_ext[k+2]),
            .c   (c_filt[k])
        );
    end

    // A hole is a 0 with a 1 directly above it; any hole makes the word illegal.
    assign c_zero = (c_filt == '0);
    assign c_hole = |(~c_filt[N-2:0] & c_filt[N-1:1]);
    assign c_bub  = (c_filt != din) || (!c_zero && c_hole);

    // ---------------------------------------------------------- handshake
    logic s1_valid_q, s1_valid_d;
    logic dout_valid_q, dout_valid_d;
    logic s1_load, s2_load, s2_xfer;

    assign s2_load   = s1_valid_q && (!dout_valid_q || dout_ready);
    assign din_ready = !s1_valid_q || s2_load;
    assign s1_load   = din_valid && din_ready;
    assign s2_xfer   = dout_valid_q && dout_ready;

    // ---------------------------------------------------------------- stage 1
    s1_t s1_q, s1_d;

    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        if (s1_load) begin
            s1_d.c     = c_filt;
            s1_d.bub   = c_bub;
            s1_d.zero  = c_zero;
            s1_valid_d = 1'b1;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s1_valid_q <= s1_valid_d;
        end
    end

    // ---------------------------------------------------------------- encoder
    // Highest set bit wins; an all-zero word encodes as 0 and is flagged.
    logic [WIDTH-1:0] enc_idx;

    always_comb begin
        enc_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (s1_q.c[k]) enc_idx = WIDTH'(k);
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             bubble_err_q, bubble_err_d;
    logic             zero_err_q, zero_err_d;

    always_comb begin
        dout_d       = dout_q;
        bubble_err_d = bubble_err_q;
        zero_err_d   = zero_err_q;
        dout_valid_d = dout_valid_q;
        if (s2_load) begin
            dout_d       = enc_idx;
            bubble_err_d = s1_q.bub;
            zero_err_d   = s1_q.zero;
            dout_valid_d = 1'b1;
        end else if (dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout_q       <= '0;
            bubble_err_q <= 1'b0;
            zero_err_q   <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            bubble_err_q <= bubble_err_d;
            zero_err_q   <= zero_err_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // ------------------------------------------------------------ err counter
    logic [CNT_W-1:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (s2_xfer && (bubble_err_q || zero_err_q) && !(&err_count_q)) begin
            err_count_d = err_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) err_count_q <= '0;
        else         err_count_q <= err_count_d;
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign bubble_err = bubble_err_q;
    assign zero_err   = zero_err_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_therm_to_bin_pipe.sv
// Random and directed stimulus for therm_to_bin_pipe, checked against a
// word-level reference model and an in-flight queue. A second instance with a
// 4-bit counter shares all inputs to exercise counter saturation.
module tb_therm_to_bin_pipe;
    localparam int WIDTH = 8;
    localparam int N     = 256;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic [N-1:0]     din = '0;
    logic             din_valid = 1'b0;
    logic             dout_ready = 1'b0;

    logic             din_ready, dout_valid, bubble_err, zero_err;
    logic [WIDTH-1:0] dout;
    logic [15:0]      err_count;
    logic             din_ready4, dout_valid4, bubble_err4, zero_err4;
    logic [WIDTH-1:0] dout4;
    logic [3:0]       err_count4;

    therm_to_bin_pipe #(.WIDTH(WIDTH), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .bubble_err(bubble_err), .zero_err(zero_err),
        .err_count(err_count));

    therm_to_bin_pipe #(.WIDTH(WIDTH), .CNT_W(4)) dut4 (
        .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid),
        .din_ready(din_ready4), .dout(dout4), .dout_valid(dout_valid4),
        .dout_ready(dout_ready), .bubble_err(bubble_err4), .zero_err(zero_err4),
        .err_count(err_count4));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             b;
        logic             z;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_out;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cnt_model = 0;

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: majority filter from the three-neighbour vote, legality as
    // "c+1 is a power of two", index as the highest set position.
    function automatic exp_t ref_enc(input logic [N-1:0] t);
        logic [N-1:0] c;
        logic [N:0]   cc;
        int           s;
        bit           legal;
        exp_t         e;
        for (int k = 0; k < N; k++) begin
            s = ((k == 0) ? 1 : int'(t[k-1])) + int'(t[k]) + ((k == N-1) ? 0 : int'(t[k+1]));
            c[k] = (s >= 2);
        end
        cc    = {1'b0, c};
        e.z   = (c == '0);
        legal = !e.z && (((cc + 1) & cc) == '0);
        e.b   = (c != t) || (!e.z && !legal);
        e.d   = '0;
        for (int k = 0; k < N; k++) if (c[k]) e.d = WIDTH'(k);
        return e;
    endfunction

    function automatic logic [N-1:0] therm(input int i);
        logic [N-1:0] w;
        w = '0;
        for (int k = 0; k <= i; k++) w[k] = 1'b1;
        return w;
    endfunction

    // Monitor: everything sampled on the falling edge.
    initial begin
        exp_t        e;
        logic        prev_stall;
        logic [WIDTH-1:0] prev_dout;
        logic [1:0]  prev_fl;
        int          sat4;
        prev_stall = 1'b0;
        prev_dout  = '0;
        prev_fl    = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                exp_q.delete();
                cnt_model  = 0;
                prev_stall = 1'b0;
            end else begin
                sat4 = (cnt_model > 15) ? 15 : cnt_model;
                chk("din_ready", din_ready, (exp_q.size() < 2) || dout_ready);
                chk("din_ready4", din_ready4, (exp_q.size() < 2) || dout_ready);
                chk("err_count", err_count, cnt_model);
                chk("err_count4", err_count4, sat4);
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", dout_valid, 0);
                    chk("spurious_valid4", dout_valid4, 0);
                end
                if (prev_stall) begin
                    chk("hold_valid", dout_valid, 1);
                    chk("hold_dout", dout, prev_dout);
                    chk("hold_flags", {bubble_err, zero_err}, prev_fl);
                end
                if (dout_valid && dout_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("dout", dout, e.d);
                    chk("bubble_err", bubble_err, e.b);
                    chk("zero_err", zero_err, e.z);
                    chk("dout4", {dout4, bubble_err4, zero_err4, dout_valid4}, {e.d, e.b, e.z, 1'b1});
                    last_out = '{dout, bubble_err, zero_err};
                    if (e.b || e.z) cnt_model++;
                end
                prev_stall = dout_valid && !dout_ready;
                prev_dout  = dout;
                prev_fl    = {bubble_err, zero_err};
                if (din_valid && din_ready) exp_q.push_back(ref_enc(din));
            end
        end
    end

    // One driver cycle: inputs set just after a rising edge, acceptance
    // judged at the falling edge, returns just after the next rising edge.
    task automatic cycle(input logic v, input logic [N-1:0] w, input logic r, output bit acc);
        din_valid  = v;
        din        = w;
        dout_ready = r;
        @(negedge clk);
        acc = v && din_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] w);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) cycle(1'b1, w, 1'b1, acc);
        chk("send_accepted", acc, 1);
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) cycle(1'b0, '0, 1'b1, acc);
        chk("drained", exp_q.size(), 0);
    endtask

    function automatic logic [N-1:0] rand_word();
        logic [N-1:0] w;
        case ($urandom_range(0, 4))
            0: w = therm($urandom_range(0, N-1));
            1: begin
                w = therm($urandom_range(0, N-1));
                for (int j = 0; j < int'($urandom_range(1, 3)); j++) w[$urandom_range(0, N-1)] ^= 1'b1;
            end
            2: w = '0;
            3: for (int k = 0; k < N/32; k++) w[k*32 +: 32] = $urandom();
            default: begin
                w = '0;
                w[$urandom_range(0, N-1)] = 1'b1;
            end
        endcase
        return w;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        logic [N-1:0] w;
        logic [N-1:0] src[$];
        int c;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", dout_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_flags", {bubble_err, zero_err}, 0);
        chk("rst_cnt", err_count, 0);
        resetn = 1'b1;
        #1;
        chk("rst_ready", din_ready, 1);
        @(posedge clk);
        #1;

        // Clean code, two-cycle latency
        cycle(1'b1, therm(5), 1'b1, acc);
        chk("lat_acc", acc, 1);
        chk("lat_early", dout_valid, 0);
        cycle(1'b0, '0, 1'b1, acc);
        chk("lat_valid", dout_valid, 1);
        chk("lat_dout", dout, 5);
        chk("lat_flags", {bubble_err, zero_err}, 0);
        drain();

        // Sweep of all legal codes, back-to-back
        for (int i = 0; i < N; i++) send(therm(i));
        drain();
        chk("sweep_cnt", err_count, 0);

        // Single bubble
        w = therm(7);
        w[3] = 1'b0;
        send(w);
        drain();
        chk("bub_out", last_out, {8'd7, 1'b1, 1'b0});
        chk("bub_cnt", err_count, 1);

        // Illegal words
        send('0);
        drain();
        chk("zero_out", last_out, {8'd0, 1'b0, 1'b1});
        w = '0;
        w[0] = 1'b1;
        w[200] = 1'b1;
        send(w);
        drain();
        chk("iso_out", last_out, {8'd0, 1'b1, 1'b0});
        send('1);
        drain();
        chk("ones_out", last_out, {8'd255, 1'b0, 1'b0});
        chk("ill_cnt", err_count, 3);

        // Backpressure: dout_ready 1-on/2-off
        for (int i = 0; i < 10; i++) src.push_back(therm($urandom_range(0, N-1)));
        c = 0;
        while (src.size() > 0 && c < 200) begin
            cycle(1'b1, src[0], (c % 3) == 0, acc);
            if (acc) void'(src.pop_front());
            c++;
        end
        chk("bp_sent", src.size(), 0);
        drain();
        chk("bp_cnt", err_count, 3);

        // Counter saturation on the 4-bit instance
        for (int i = 0; i < 20; i++) send('0);
        drain();
        chk("sat4", err_count4, 15);
        chk("sat16", err_count, 23);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 9) < 7, acc);
        end
        drain();

        // Reset with both stages full
        cycle(1'b1, therm(10), 1'b0, acc);
        cycle(1'b1, therm(20), 1'b0, acc);
        cycle(1'b1, therm(30), 1'b0, acc);
        chk("full_blocked", acc, 0);
        chk("full_valid", dout_valid, 1);
        resetn = 1'b0;
        din_valid = 1'b0;
        #1;
        chk("mid_rst_valid", dout_valid, 0);
        chk("mid_rst_cnt", err_count, 0);
        chk("mid_rst_cnt4", err_count4, 0);
        chk("mid_rst_out", {dout, bubble_err, zero_err}, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        #1;
        chk("post_rst_ready", din_ready, 1);
        @(posedge clk);
        #1;
        cycle(1'b1, therm(5), 1'b1, acc);
        chk("post_acc", acc, 1);
        chk("post_stale", dout_valid, 0);
        cycle(1'b0, '0, 1'b1, acc);
        chk("post_valid", dout_valid, 1);
        chk("post_dout", dout, 5);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
